// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encoding and
//   the default operand width.
package serial_adder_pkg;

   localparam int unsigned N_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : serial_adder_pkg

// File: rtl/adder_1.sv
// adder_1
//   Single-bit full adder; the only arithmetic element on the serial
//   adder datapath.
//   Ports:
//     a, b   : operand bits
//     c_in   : carry in
//     sum    : a ^ b ^ c_in
//     c_out  : carry out
module adder_1 (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   logic p;

   always_comb begin
      p     = a ^ b;
      sum   = p ^ c_in;
      c_out = (a & b) | (c_in & p);
   end

endmodule : adder_1

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial N-bit adder. Operands are accepted in IDLE, summed LSB first
//   through one full adder over N RUN cycles, and the result is held in DONE
//   until the consumer accepts it. The last result stays on the outputs
//   through the following IDLE.
//   Ports:
//     clk, rst_n          : clock, async active-low reset
//     in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//     a, b, c_in          : operands and carry into bit 0
//     out_valid/out_ready : result handshake (out_valid high only in DONE)
//     sum                 : low N bits of a + b + c_in
//     c_out               : carry out of bit N-1
//     overflow            : carry into bit N-1 XOR carry out of bit N-1
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         c_out,
   output logic         overflow
);

   localparam int unsigned   CW   = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e        state_q, state_d;
   logic [N-1:0]  a_sr_q, a_sr_d;
   logic [N-1:0]  b_sr_q, b_sr_d;
   logic [N-1:0]  sum_q, sum_d;
   logic          carry_q, carry_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cmsb_q, cmsb_d;
   logic          c_out_q, c_out_d;

   logic          fa_sum;
   logic          fa_cout;

   adder_1 u_adder_1 (
      .a     (a_sr_q[0]),
      .b     (b_sr_q[0]),
      .c_in  (carry_q),
      .sum   (fa_sum),
      .c_out (fa_cout)
   );

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      cmsb_d  = cmsb_q;
      c_out_d = c_out_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = c_in;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            // Sum bits enter at the MSB end so that after N shifts bit 0
            // of the result has reached sum_q[0].
            sum_d   = {fa_sum, sum_q[N-1:1]};
            a_sr_d  = {1'b0, a_sr_q[N-1:1]};
            b_sr_d  = {1'b0, b_sr_q[N-1:1]};
            carry_d = fa_cout;
            if (cnt_q == LAST) begin
               // carry_q here is the carry into the MSB; fa_cout the carry out.
               cmsb_d  = carry_q;
               c_out_d = fa_cout;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         cmsb_q  <= 1'b0;
         c_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         cmsb_q  <= cmsb_d;
         c_out_q <= c_out_d;
      end
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      sum       = sum_q;
      c_out     = c_out_q;
      overflow  = cmsb_q ^ c_out_q;
   end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic        clk;
   logic        rst_n;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, ovf8;
   logic [7:0]  a8, b8, sum8;
   logic        in_valid16, in_ready16, out_valid16, out_ready16, cin16, cout16, ovf16;
   logic [15:0] a16, b16, sum16;

   bit          wide;
   logic        sel_in_ready, sel_out_valid, sel_cout, sel_ovf;
   logic [15:0] sel_sum;

   int n_tests = 0;
   int n_fail  = 0;

   serial_adder #(.N(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .c_in      (cin8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .sum       (sum8),
      .c_out     (cout8),
      .overflow  (ovf8)
   );

   serial_adder #(.N(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .a         (a16),
      .b         (b16),
      .c_in      (cin16),
      .out_valid (out_valid16),
      .out_ready (out_ready16),
      .sum       (sum16),
      .c_out     (cout16),
      .overflow  (ovf16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      sel_in_ready  = wide ? in_ready16  : in_ready8;
      sel_out_valid = wide ? out_valid16 : out_valid8;
      sel_sum       = wide ? sum16       : {8'h00, sum8};
      sel_cout      = wide ? cout16      : cout8;
      sel_ovf       = wide ? ovf16       : ovf8;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit w, input logic v, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic ordy);
      if (w) begin
         in_valid16 = v; a16 = av; b16 = bv; cin16 = ci; out_ready16 = ordy;
      end else begin
         in_valid8 = v; a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci; out_ready8 = ordy;
      end
   endtask

   // Reference: plain wide add, overflow from operand/result sign bits.
   function automatic logic [17:0] ref_add(input bit w, input logic [15:0] av,
                                           input logic [15:0] bv, input logic ci);
      logic [16:0] full;
      logic [8:0]  half;
      logic        ov;
      if (w) begin
         full = {1'b0, av} + {1'b0, bv} + {16'h0, ci};
         ov   = (av[15] == bv[15]) && (full[15] != av[15]);
         return {ov, full[16], full[15:0]};
      end else begin
         half = {1'b0, av[7:0]} + {1'b0, bv[7:0]} + {8'h0, ci};
         ov   = (av[7] == bv[7]) && (half[7] != av[7]);
         return {ov, half[8], 8'h00, half[7:0]};
      end
   endfunction

   task automatic run_op(input bit w, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input int hold, input bit noisy, input string tag);
      int lat;
      int n;
      n    = w ? 16 : 8;
      wide = w;
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(sel_in_ready), 32'd1);
      drive(w, 1'b1, av, bv, ci, 1'b0);
      @(negedge clk);
      drive(w, noisy, ~av, ~bv, ~ci, noisy);
      lat = 0;
      while (!sel_out_valid && lat < 40) begin
         if (noisy) drive(w, lat[0], ~av, bv, ci, ~lat[0]);
         @(negedge clk);
         lat++;
      end
      drive(w, 1'b0, av, bv, ci, 1'b0);
      chk({tag, ".latency"}, 32'(lat), 32'(n));
      chk({tag, ".sum"},     32'(sel_sum),  32'(es));
      chk({tag, ".c_out"},   32'(sel_cout), 32'(ec));
      chk({tag, ".ovf"},     32'(sel_ovf),  32'(eo));
      for (int k = 0; k < hold; k++) begin
         drive(w, 1'b1, ~bv, av, ci, 1'b0);
         @(negedge clk);
         chk({tag, ".hold_valid"}, 32'(sel_out_valid), 32'd1);
         chk({tag, ".hold_sum"},   32'(sel_sum),       32'(es));
      end
      drive(w, 1'b0, av, bv, ci, 1'b1);
      @(negedge clk);
      drive(w, 1'b0, av, bv, ci, 1'b0);
      chk({tag, ".post_valid"}, 32'(sel_out_valid), 32'd0);
      chk({tag, ".post_ready"}, 32'(sel_in_ready),  32'd1);
      chk({tag, ".retain_sum"}, 32'(sel_sum),       32'(es));
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rc;
      logic [17:0] r;

      wide = 1'b0;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #1;
      chk("rst.in_ready",  32'(in_ready8),  32'd1);
      chk("rst.out_valid", 32'(out_valid8), 32'd0);
      chk("rst.sum",       32'(sum8),       32'd0);
      chk("rst.c_out",     32'(cout8),      32'd0);
      chk("rst.ovf",       32'(ovf8),       32'd0);
      chk("rst.sum16",     32'(sum16),      32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed N=8 vectors
      run_op(1'b0, 16'h0F, 16'h01, 1'b0, 16'h10, 1'b0, 1'b0, 0, 1'b0, "d8_0f_01");
      run_op(1'b0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, 0, 1'b0, "d8_ff_01");
      run_op(1'b0, 16'h7F, 16'h00, 1'b1, 16'h80, 1'b0, 1'b1, 0, 1'b0, "d8_7f_00_c");
      run_op(1'b0, 16'h80, 16'h80, 1'b0, 16'h00, 1'b1, 1'b1, 0, 1'b0, "d8_80_80");
      run_op(1'b0, 16'hA5, 16'h5A, 1'b1, 16'h00, 1'b1, 1'b0, 5, 1'b1, "d8_hold_noisy");

      // Reset in the middle of RUN discards the operation
      wide = 1'b0;
      @(negedge clk);
      drive(1'b0, 1'b1, 16'hAA, 16'h55, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h00, 16'h00, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("midrun.busy", 32'(in_ready8), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrun.out_valid", 32'(out_valid8), 32'd0);
      chk("midrun.sum",       32'(sum8),       32'd0);
      chk("midrun.in_ready",  32'(in_ready8),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrun.release_valid", 32'(out_valid8), 32'd0);
      run_op(1'b0, 16'h12, 16'h34, 1'b0, 16'h46, 1'b0, 1'b0, 0, 1'b0, "d8_after_rst");

      // Directed N=16 vectors
      run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, "d16_ffff_1");
      run_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0, "d16_7fff_1");
      run_op(1'b1, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0, 0, 1'b0, "d16_8000_ffff_c");
      run_op(1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 2, 1'b1, "d16_1234_4321_c");

      // Random sweep against the reference add
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         r  = ref_add(1'b0, ra, rb, rc);
         run_op(1'b0, ra, rb, rc, r[15:0], r[16], r[17], 0, 1'(i), "rnd8");
      end
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         r  = ref_add(1'b1, ra, rb, rc);
         run_op(1'b1, ra, rb, rc, r[15:0], r[16], r[17], 0, 1'(i), "rnd16");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter N, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operands a, b, c_in presented.
REQ-005 in_ready  output  1  block can accept operands (high only in IDLE).
REQ-006 a  input  N  operand A, unsigned/two's-complement agnostic.
REQ-007 b  input  N  operand B.
REQ-008 c_in  input  1  carry into bit 0.
REQ-009 out_valid  output  1  result held on sum/c_out/overflow.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  N  a + b + c_in, low N bits.
REQ-012 c_out  output  1  carry out of bit N-1.
REQ-013 overflow  output  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.

Function
REQ-014 Three-state FSM: IDLE, RUN, DONE; encoding in shared package.
REQ-015 IDLE: in_ready=1; on in_valid=1 capture a, b into shift registers, c_in into carry flop, clear bit counter, go to RUN.
REQ-016 RUN: each cycle one bit processed LSB first via one 1-bit full adder: inputs = a_sr[0], b_sr[0], carry flop.
REQ-017 RUN: adder sum bit shifted into sum register from MSB end; a_sr, b_sr shift right by one; carry flop <= adder carry out; counter increments.
REQ-018 RUN: on cycle where counter == N-1, capture carry flop value as carry-into-MSB for overflow, then go to DONE.
REQ-019 Latency: accept edge at cycle 0 -> out_valid high from cycle N+1 (exactly N RUN cycles).
REQ-020 DONE: out_valid=1; sum, c_out, overflow stable; on out_ready=1 go to IDLE next edge.
REQ-021 in_valid ignored outside IDLE; operands not re-sampled mid-operation.
REQ-022 out_ready ignored outside DONE.
REQ-023 Back-to-back: in_ready rises the cycle after DONE handshake; no same-cycle DONE->RUN bypass.
REQ-024 sum/c_out/overflow retain last result in IDLE; undefined-looking partial values permitted on sum during RUN, out_valid low.
REQ-025 Bit counter width $clog2(N); no wrap past N-1.
REQ-026 Arithmetic identical to an N-bit ripple-carry add of a, b, c_in (modulo 2^N plus carry).

Reset
REQ-027 rst_n low at any time (incl. mid-RUN or DONE) immediately forces IDLE, in_ready=1 after release, out_valid=0.
REQ-028 Reset values: sum=0, c_out=0, overflow=0, carry flop=0, counter=0, shift registers=0.
REQ-029 Operation in progress at reset is discarded; no result produced.

Structure
REQ-030 Shared package serial_adder_pkg holds FSM state enum typedef and default N constant.
REQ-031 Single sub-module: adder_1 (1-bit full adder: a, b, c_in -> sum, c_out), instantiated once; no other arithmetic operators on the datapath.
REQ-032 Next-state/output logic in always_comb; all flops in one always_ff sensitive to posedge clk, negedge rst_n.

Verification
REQ-033 N=8, a=8'h0F, b=8'h01, c_in=0 -> after 8 RUN cycles sum=8'h10, c_out=0, overflow=0, out_valid cycle 9.
REQ-034 N=8, a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1, overflow=0.
REQ-035 N=8, a=8'h7F, b=8'h00, c_in=1 -> sum=8'h80, c_out=0, overflow=1.
REQ-036 out_ready held low 5 cycles in DONE -> out_valid and sum stay stable; in_valid pulses in RUN/DONE ignored.
REQ-037 rst_n asserted at RUN cycle 4 -> out_valid=0, sum=0 immediately; next operand pair 8'h12+8'h34 -> sum=8'h46.
REQ-038 Random sweep 1000 operand pairs, N=8 and N=16 -> results match reference N-bit add including c_out and overflow.
